// File: rtl/display_pkg.sv
// display_pkg: shared constants, defaults and width helper for the multiplexed 7-segment display
package display_pkg;
    typedef logic [7:0] seg_t;
    localparam seg_t SEG_APAGADO = 8'hFF;
    localparam int NUM_DIGITOS_PADRAO = 4;
    localparam int DIV_VARREDURA_PADRAO = 50000;
    localparam int CICLOS_APAGADO_PADRAO = 2;
    localparam int DIV_PISCA_PADRAO = 32;
    function automatic int largura(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/contador_varredura.sv
// contador_varredura: slot prescaler and digit index with slot/frame wrap flags
module contador_varredura
    import display_pkg::*;
#(
    parameter int NUM_DIGITOS = NUM_DIGITOS_PADRAO,
    parameter int DIV_VARREDURA = DIV_VARREDURA_PADRAO,
    localparam int CW = largura(DIV_VARREDURA),
    localparam int IW = largura(NUM_DIGITOS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          habilitar,
    output logic [CW-1:0] cnt,
    output logic [IW-1:0] idx,
    output logic          fim_slot,
    output logic          fim_quadro
);
    assign fim_slot = cnt == CW'(DIV_VARREDURA - 1);
    assign fim_quadro = fim_slot && idx == IW'(NUM_DIGITOS - 1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (!habilitar) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= fim_slot ? '0 : cnt + 1'b1;
            if (fim_slot)
                idx <= fim_quadro ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/varredura_display.sv
// varredura_display: multiplexed 7-segment scanner with shadow/active buffering, anti-ghosting and blink
module varredura_display
    import display_pkg::*;
#(
    parameter int NUM_DIGITOS = NUM_DIGITOS_PADRAO,
    parameter int DIV_VARREDURA = DIV_VARREDURA_PADRAO,
    parameter int CICLOS_APAGADO = CICLOS_APAGADO_PADRAO,
    parameter int DIV_PISCA = DIV_PISCA_PADRAO
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     habilitar,
    input  logic [8*NUM_DIGITOS-1:0] segmentos_in,
    input  logic                     carregar,
    input  logic [NUM_DIGITOS-1:0]   piscar_mascara,
    output logic [7:0]               segmentos,
    output logic [NUM_DIGITOS-1:0]   digitos,
    output logic                     fim_quadro,
    output logic                     pendente
);
    localparam int CW = largura(DIV_VARREDURA);
    localparam int IW = largura(NUM_DIGITOS);
    localparam int FW = largura(DIV_PISCA);
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic fim_slot, fim_frm, virada, commit, escuro, fase;
    logic [FW-1:0] cnt_quadros;
    logic [NUM_DIGITOS-1:0] dig_n;
    seg_t [NUM_DIGITOS-1:0] sombra, ativo;
    contador_varredura #(.NUM_DIGITOS(NUM_DIGITOS), .DIV_VARREDURA(DIV_VARREDURA)) u_contador (
        .clock(clock), .reset(reset), .habilitar(habilitar),
        .cnt(cnt), .idx(idx), .fim_slot(fim_slot), .fim_quadro(fim_frm)
    );
    assign virada = habilitar && fim_slot && fim_frm;
    // shadow only reaches the display at a frame boundary, or at once while the scan is stopped
    assign commit = pendente && (virada || !habilitar);
    always_comb begin
        escuro = !habilitar || cnt < CW'(CICLOS_APAGADO) || (fase && piscar_mascara[idx]);
        dig_n = '1;
        if (!escuro)
            dig_n[idx] = 1'b0;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            segmentos <= SEG_APAGADO;
            digitos <= '1;
            fim_quadro <= 1'b0;
            pendente <= 1'b0;
            sombra <= '1;
            ativo <= '1;
            cnt_quadros <= '0;
            fase <= 1'b0;
        end else begin
            segmentos <= escuro ? SEG_APAGADO : ativo[idx];
            digitos <= dig_n;
            fim_quadro <= virada;
            if (commit)
                ativo <= sombra;
            if (carregar)
                sombra <= segmentos_in;
            pendente <= carregar || (pendente && !commit);
            if (!habilitar) begin
                cnt_quadros <= '0;
                fase <= 1'b0;
            end else if (virada) begin
                cnt_quadros <= cnt_quadros == FW'(DIV_PISCA - 1) ? '0 : cnt_quadros + 1'b1;
                if (cnt_quadros == FW'(DIV_PISCA - 1))
                    fase <= !fase;
            end
        end
    end
endmodule

// File: tb/tb_varredura_display.sv
// tb_varredura_display: randomized scoreboard bench against a positional reference model
module tb_varredura_display;
    localparam int N = 4, DIV = 8, APAG = 2, PISCA = 2;
    localparam int QUADRO = N * DIV;
    typedef struct packed {
        logic [7:0] seg;
        logic [N-1:0] dig;
        logic fim;
        logic pend;
    } exp_t;
    logic clock = 0, reset = 0, habilitar = 0, carregar = 0;
    logic [8*N-1:0] segmentos_in = '0;
    logic [N-1:0] piscar_mascara = '0;
    logic [7:0] segmentos;
    logic [N-1:0] digitos;
    logic fim_quadro, pendente;
    exp_t q[$];
    int checks = 0, passes = 0;
    logic [7:0] act[N], shd[N];
    logic pend_m;
    int p;
    varredura_display #(.NUM_DIGITOS(N), .DIV_VARREDURA(DIV), .CICLOS_APAGADO(APAG), .DIV_PISCA(PISCA)) dut (
        .clock(clock), .reset(reset), .habilitar(habilitar), .segmentos_in(segmentos_in),
        .carregar(carregar), .piscar_mascara(piscar_mascara), .segmentos(segmentos),
        .digitos(digitos), .fim_quadro(fim_quadro), .pendente(pendente)
    );
    always #5 clock = ~clock;
    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp)
            passes++;
        else
            $display("FAIL %s at %0t: got %0h expected %0h", nome, $time, got, exp);
    endtask
    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            act[i] = 8'hFF;
            shd[i] = 8'hFF;
        end
        pend_m = 0;
        p = 0;
    endtask
    // one clock edge of the reference model, expressed as position within the enabled scan
    task automatic model_step();
        exp_t e;
        bit fim, com, escuro;
        int slot_pos, dig_i, fase;
        if (!habilitar) begin
            e.seg = 8'hFF;
            e.dig = '1;
            fim = 0;
            com = pend_m;
            p = 0;
        end else begin
            slot_pos = p % DIV;
            dig_i = (p / DIV) % N;
            fase = (p / (QUADRO * PISCA)) % 2;
            escuro = slot_pos < APAG || (fase == 1 && piscar_mascara[dig_i]);
            e.seg = escuro ? 8'hFF : act[dig_i];
            e.dig = escuro ? '1 : ~(N'(1) << dig_i);
            fim = (p % QUADRO) == QUADRO - 1;
            com = pend_m && fim;
            p++;
        end
        e.fim = fim;
        e.pend = carregar || (pend_m && !com);
        pend_m = e.pend;
        for (int i = 0; i < N; i++) begin
            if (com)
                act[i] = shd[i];
            if (carregar)
                shd[i] = segmentos_in[8*i +: 8];
        end
        q.push_back(e);
    endtask
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("segmentos", 32'(segmentos), 32'(e.seg));
            chk("digitos", 32'(digitos), 32'(e.dig));
            chk("fim_quadro", 32'(fim_quadro), 32'(e.fim));
            chk("pendente", 32'(pendente), 32'(e.pend));
        end
    end
    initial begin
        int off = 0;
        model_reset();
        #2 reset = 1;
        #1;
        chk("reset_seg", 32'(segmentos), 32'hFF);
        chk("reset_dig", 32'(digitos), 32'hF);
        chk("reset_fim", 32'(fim_quadro), 0);
        chk("reset_pend", 32'(pendente), 0);
        repeat (2) @(negedge clock);
        reset = 0;
        habilitar = 1;
        segmentos_in = 32'h9FF9_2503;
        carregar = 1;
        model_step();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if (i == 1500) begin
                @(posedge clock);
                #3 reset = 1;
                #1;
                chk("async_reset_seg", 32'(segmentos), 32'hFF);
                chk("async_reset_dig", 32'(digitos), 32'hF);
                chk("async_reset_pend", 32'(pendente), 0);
                chk("async_reset_fim", 32'(fim_quadro), 0);
                @(negedge clock);
                reset = 0;
                model_reset();
            end
            if (off > 0) begin
                habilitar = 0;
                off--;
            end else if ($urandom % 250 == 0) begin
                habilitar = 0;
                off = $urandom_range(0, 4);
            end else
                habilitar = 1;
            carregar = ($urandom % 24 == 0) || i == 1499 ||
                       (habilitar && (p % QUADRO) == QUADRO - 1 && $urandom % 2 == 0);
            segmentos_in = $urandom;
            if ($urandom % 40 == 0)
                piscar_mascara = N'($urandom);
            model_step();
        end
        @(negedge clock);
        carregar = 0;
        @(negedge clock);
        chk("queue_drained", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/varredura_display.md
VARREDURA_DISPLAY -- requirements
Module: varredura_display

Interface
REQ-001 Parameter NUM_DIGITOS, default 4, number of multiplexed 7-segment digits (legal 1..8).
REQ-002 Parameter DIV_VARREDURA, default 50000, clock cycles per digit slot (legal > CICLOS_APAGADO).
REQ-003 Parameter CICLOS_APAGADO, default 2, anti-ghosting dead cycles at start of each slot (legal >= 0).
REQ-004 Parameter DIV_PISCA, default 32, frames per blink half-period (legal >= 1).
REQ-005 Port clock  in  1  sole clock; all state on rising edge.
REQ-006 Port reset  in  1  asynchronous, active-high reset.
REQ-007 Port habilitar  in  1  1 = scan running; 0 = display dark.
REQ-008 Port segmentos_in  in  8*NUM_DIGITOS  active-low pattern per digit, digit i at [8i+7:8i], order {a,b,c,d,e,f,g,dp} MSB first.
REQ-009 Port carregar  in  1  one-cycle strobe capturing segmentos_in into shadow register.
REQ-010 Port piscar_mascara  in  NUM_DIGITOS  bit i = 1 makes digit i blink.
REQ-011 Port segmentos  out  8  active-low segment drive {a,b,c,d,e,f,g,dp}.
REQ-012 Port digitos  out  NUM_DIGITOS  active-low digit enables, bit i = digit i.
REQ-013 Port fim_quadro  out  1  one-cycle pulse at end of each full scan frame.
REQ-014 Port pendente  out  1  shadow holds data not yet committed to display.

Function
REQ-015 Internal slot counter cnt SHALL count 0..DIV_VARREDURA-1 and wrap; on wrap, digit index idx SHALL advance 0..NUM_DIGITOS-1 and wrap to 0.
REQ-016 All outputs SHALL be registered and lag internal (cnt, idx) state by exactly one clock.
REQ-017 While cnt < CICLOS_APAGADO, digitos SHALL be all-ones and segmentos 8'hFF.
REQ-018 Otherwise digitos SHALL have only bit idx low and segmentos SHALL equal the active register slice for idx.
REQ-019 carregar SHALL copy segmentos_in into shadow register and set pendente.
REQ-020 Commit (shadow -> active, clear pendente) SHALL occur only on frame wrap (idx = NUM_DIGITOS-1, cnt = DIV_VARREDURA-1) with pendente set; no mid-frame tearing.
REQ-021 carregar coincident with commit: active SHALL take previous shadow, shadow SHALL take new segmentos_in, pendente SHALL remain 1.
REQ-022 fim_quadro SHALL pulse for one cycle per frame wrap, including frames without commit.
REQ-023 Frame counter SHALL count frame wraps 0..DIV_PISCA-1; on its wrap blink phase SHALL toggle.
REQ-024 In blink phase 1, digits with piscar_mascara bit set SHALL show digitos all-ones and segmentos 8'hFF for their whole slot.
REQ-025 habilitar = 0 SHALL hold cnt, idx, frame counter and blink phase at 0, drive all outputs dark, hold fim_quadro 0.
REQ-026 While habilitar = 0, a pending shadow SHALL commit on the next clock edge.
REQ-027 Rising habilitar SHALL restart scan at cnt = 0, idx = 0.

Reset
REQ-028 reset SHALL asynchronously force segmentos = 8'hFF, digitos all-ones, fim_quadro = 0, pendente = 0.
REQ-029 reset SHALL set active and shadow registers to all-ones (blank), all counters and blink phase to 0.
REQ-030 After reset release, first edge with habilitar = 1 SHALL be cnt = 0 of slot 0.

Structure
REQ-031 Shared package display_pkg SHALL hold SEG_APAGADO = 8'hFF and parameter defaults.
REQ-032 Prescaler plus digit index SHALL be sub-module contador_varredura, emitting cnt, idx, slot-wrap and frame-wrap.
REQ-033 Blink, shadow/active registers and output registers SHALL reside in varredura_display.

Verification (NUM_DIGITOS=4, DIV_VARREDURA=8, CICLOS_APAGADO=2, DIV_PISCA=2)
REQ-034 Reset, habilitar=1, load 0x9FF9_2503 -> each 8-cycle slot: 2 dark cycles then digitos 1110/1101/1011/0111 with 0x03/0x25/0xF9/0x9F; fim_quadro every 32 cycles.
REQ-035 carregar new data mid-frame -> pendente=1, old pattern until fim_quadro, new pattern from next frame, pendente=0.
REQ-036 piscar_mascara=4'b0010 -> digit 1 visible in frames 0,1,4,5, dark in frames 2,3; other digits unaffected.
REQ-037 carregar on frame-wrap cycle -> committed value is prior shadow, pendente stays 1, new data appears one frame later.
REQ-038 habilitar dropped mid-slot with pendente=1 -> outputs dark next cycle, pendente cleared; re-enable restarts at digit 0 showing committed data.
REQ-039 reset asserted mid-slot between clock edges -> segmentos=8'hFF, digitos=1111 immediately, no clock required.
